// File: rtl/pattern_fill_engine.sv
// Restartable VRAM test-pattern writer: walks an FB_WIDTH x FB_HEIGHT framebuffer
// and writes one 16-bit pattern word per pixel over the sel/wr/ack handshake.
module pattern_fill_engine #(
    parameter int          FB_WIDTH  = 128,
    parameter int          FB_HEIGHT = 128,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          CELL_LOG2 = 3,
    parameter int          BAR_LOG2  = 4
) (
    input  logic        clk,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] color0_i,
    input  logic [15:0] color1_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        aborted_o,
    input  logic        vram_ack_i,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [31:0] vram_addr_o,
    output logic [15:0] vram_data_out_o
);

    localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state, state_n;
    logic [XW-1:0] x, x_n;
    logic [YW-1:0] y, y_n;
    logic [31:0]   idx, idx_n;
    logic [1:0]    mode_q, mode_n;
    logic [15:0]   c0_q, c0_n, c1_q, c1_n;
    logic          abort_pend, abort_pend_n;
    logic          sel_n, wr_n, busy_n, done_n, aborted_n;
    logic [31:0]   addr_n;
    logic [15:0]   data_n;

    logic [31:0]   xe, ye;
    logic          checker_on;
    logic [2:0]    bar_k;
    logic [15:0]   pixel;

    assign xe = 32'(x);
    assign ye = 32'(y);
    assign checker_on = ((((xe >> CELL_LOG2) ^ (ye >> CELL_LOG2)) & 32'd1) != 32'd0);
    assign bar_k = 3'((xe >> BAR_LOG2) & 32'd7);

    always_comb begin
        case (mode_q)
            MODE_SOLID:   pixel = c0_q;
            MODE_RAMP:    pixel = idx[15:0];
            MODE_CHECKER: pixel = checker_on ? c1_q : c0_q;
            default:      pixel = {bar_k[2] ? 5'h1F : 5'h00,
                                   bar_k[1] ? 6'h3F : 6'h00,
                                   bar_k[0] ? 5'h1F : 5'h00};
        endcase
    end

    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        idx_n        = idx;
        mode_n       = mode_q;
        c0_n         = c0_q;
        c1_n         = c1_q;
        abort_pend_n = abort_pend;
        sel_n        = vram_sel_o;
        wr_n         = vram_wr_o;
        addr_n       = vram_addr_o;
        data_n       = vram_data_out_o;
        busy_n       = busy_o;
        done_n       = 1'b0;
        aborted_n    = aborted_o;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    mode_n       = mode_i;
                    c0_n         = color0_i;
                    c1_n         = color1_i;
                    x_n          = '0;
                    y_n          = '0;
                    idx_n        = '0;
                    abort_pend_n = 1'b0;
                    aborted_n    = 1'b0;
                    busy_n       = 1'b1;
                    state_n      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                abort_pend_n = abort_pend | abort_i;
                sel_n        = 1'b1;
                wr_n         = 1'b1;
                addr_n       = ADDR_BASE + idx;
                data_n       = pixel;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                // An abort only takes effect once the outstanding write is acknowledged
                abort_pend_n = abort_pend | abort_i;
                if (vram_ack_i) begin
                    sel_n = 1'b0;
                    wr_n  = 1'b0;
                    if ((x == X_LAST && y == Y_LAST) || abort_pend_n) begin
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        aborted_n = abort_pend_n;
                        state_n   = S_DONE;
                    end else begin
                        if (x == X_LAST) begin
                            x_n = '0;
                            y_n = y + YW'(1);
                        end else begin
                            x_n = x + XW'(1);
                        end
                        idx_n   = idx + 32'd1;
                        state_n = S_ISSUE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state           <= S_IDLE;
            x               <= '0;
            y               <= '0;
            idx             <= '0;
            mode_q          <= '0;
            c0_q            <= '0;
            c1_q            <= '0;
            abort_pend      <= 1'b0;
            vram_sel_o      <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_mask_o     <= 4'hF;
            vram_addr_o     <= '0;
            vram_data_out_o <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            aborted_o       <= 1'b0;
        end else begin
            state           <= state_n;
            x               <= x_n;
            y               <= y_n;
            idx             <= idx_n;
            mode_q          <= mode_n;
            c0_q            <= c0_n;
            c1_q            <= c1_n;
            abort_pend      <= abort_pend_n;
            vram_sel_o      <= sel_n;
            vram_wr_o       <= wr_n;
            vram_mask_o     <= 4'hF;
            vram_addr_o     <= addr_n;
            vram_data_out_o <= data_n;
            busy_o          <= busy_n;
            done_o          <= done_n;
            aborted_o       <= aborted_n;
        end
    end

endmodule
